// File: rtl/mic_cap_pkg.sv
// Shared constants and channel-count helper for the I2S microphone array capture block.
// MIC_CAP_STEREO_EN selects both-slot capture; otherwise only left slots are kept.
package mic_cap_pkg;

    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS  = 32;

    function automatic int nch(input int num_lines);
`ifdef MIC_CAP_STEREO_EN
        return 2 * num_lines;
`else
        return num_lines;
`endif
    endfunction

endpackage

// File: rtl/mic_cap_fifo.sv
// Synchronous first-word-fall-through frame FIFO with occupancy output.
// A push while full is accepted only when a pop happens in the same cycle.
module mic_cap_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Gated read keeps the output at zero while nothing is stored, including after reset.
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mic_array_capture.sv
// I2S microphone array master: generates SCK/WS, deserialises each line, queues frames.
// Define MIC_CAP_STEREO_EN to capture both slots; default build keeps left slots only.
module mic_array_capture
    import mic_cap_pkg::*;
#(
    parameter int NUM_LINES    = 2,
    parameter int SAMPLE_WIDTH = 24,
    parameter int OUT_WIDTH    = 16,
    parameter int SCK_DIV      = 20,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst,
    input  logic                                 cap_en,
    input  logic [NUM_LINES-1:0]                 mic_data,
    output logic                                 mic_sck,
    output logic                                 mic_ws,
    output logic [nch(NUM_LINES)*OUT_WIDTH-1:0]  m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
    output logic                                 ovf,
    output logic [15:0]                          ovf_cnt,
    input  logic                                 ovf_clr
);
    localparam int NCH      = nch(NUM_LINES);
    localparam int DW       = $clog2(SCK_DIV);
    // Only the top OUT_WIDTH bits survive truncation, and they arrive first (MSB first).
    localparam int CAP_BITS = (OUT_WIDTH < SAMPLE_WIDTH) ? OUT_WIDTH : SAMPLE_WIDTH;

    logic [DW-1:0]            div;
    logic [5:0]               bit_cnt;
    logic                     sck;
    logic                     rise;
    logic                     fall;
    logic                     wrap;
    logic                     data_bit;
    logic                     en_at0;
    logic                     push;
    logic                     full;
    logic                     empty;
    logic                     ovf_ev;
    logic [NCH*OUT_WIDTH-1:0] frame;

    assign rise     = (div == DW'(SCK_DIV / 2 - 1));
    assign fall     = (div == DW'(SCK_DIV - 1));
    assign wrap     = fall && (bit_cnt == 6'(FRAME_BITS - 1));
    assign mic_sck  = sck;
    assign mic_ws   = (bit_cnt >= 6'(SLOT_BITS));
    assign data_bit = rise && (bit_cnt[4:0] != 5'd0) && (bit_cnt[4:0] <= 5'(CAP_BITS));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div     <= '0;
            bit_cnt <= '0;
            sck     <= 1'b0;
            en_at0  <= 1'b0;
        end else begin
            div <= fall ? '0 : div + 1'b1;
            if (rise)      sck <= 1'b1;
            else if (fall) sck <= 1'b0;
            if (fall)      bit_cnt <= bit_cnt + 1'b1;
            if (rise && bit_cnt == 6'd0) en_at0 <= cap_en;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
`ifdef MIC_CAP_STEREO_EN
        localparam int   LINE = k / 2;
        localparam logic SLOT = ((k % 2) == 1);
`else
        localparam int   LINE = k;
        localparam logic SLOT = 1'b0;
`endif
        logic [OUT_WIDTH-1:0] shreg;

        always_ff @(posedge sys_clk) begin
            if (data_bit && mic_ws == SLOT)
                shreg <= (shreg << 1) | OUT_WIDTH'(mic_data[LINE]);
        end

        assign frame[k*OUT_WIDTH +: OUT_WIDTH] = shreg;
    end

    // Frame is only kept if capture was enabled for its whole span (start and push).
    assign push   = wrap && en_at0 && cap_en;
    assign ovf_ev = push && full && !(m_valid && m_ready);

    mic_cap_fifo #(
        .WIDTH (NCH * OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push),
        .wdata (frame),
        .pop   (m_ready),
        .rdata (m_data),
        .empty (empty),
        .full  (full),
        .level (fifo_level)
    );

    assign m_valid = !empty;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (ovf_ev) begin
            ovf <= 1'b1;
            if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mic_array_capture.sv
// Scoreboard bench for mic_array_capture with SCK_DIV=4, FIFO_DEPTH=4, two lines.
// Honours MIC_CAP_STEREO_EN the same way as the design build.
module tb_mic_array_capture;
    localparam int NL = 2;
    localparam int SW = 24;
    localparam int OW = 16;
    localparam int SD = 4;
    localparam int FD = 4;
`ifdef MIC_CAP_STEREO_EN
    localparam int NCH = 2 * NL;
`else
    localparam int NCH = NL;
`endif
    localparam int FW = NCH * OW;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          cap_en  = 1'b0;
    logic          m_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [NL-1:0] mic_data = '0;
    logic          mic_sck;
    logic          mic_ws;
    logic          m_valid;
    logic          ovf;
    logic [FW-1:0] m_data;
    logic [2:0]    fifo_level;
    logic [15:0]   ovf_cnt;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            exp_drop = 0;
    logic [FW-1:0] sb [$];

    mic_array_capture #(
        .NUM_LINES    (NL),
        .SAMPLE_WIDTH (SW),
        .OUT_WIDTH    (OW),
        .SCK_DIV      (SD),
        .FIFO_DEPTH   (FD)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cap_en     (cap_en),
        .mic_data   (mic_data),
        .mic_sck    (mic_sck),
        .mic_ws     (mic_ws),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .ovf_cnt    (ovf_cnt),
        .ovf_clr    (ovf_clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_sck"},   64'(mic_sck),    64'd0);
        chk({p, "_ws"},    64'(mic_ws),     64'd0);
        chk({p, "_valid"}, 64'(m_valid),    64'd0);
        chk({p, "_data"},  64'(m_data),     64'd0);
        chk({p, "_level"}, 64'(fifo_level), 64'd0);
        chk({p, "_ovf"},   64'(ovf),        64'd0);
        chk({p, "_cnt"},   64'(ovf_cnt),    64'd0);
    endtask

    // Consumer side of the scoreboard: every accepted output frame is compared in order.
    always @(negedge sys_clk) begin
        if (!sys_rst && m_valid && m_ready) begin
            if (sb.size() == 0) chk("unexpected_frame", 64'(sb.size()), 64'd1);
            else                chk("frame_data", 64'(m_data), 64'(sb.pop_front()));
        end
    end

    // Drives one frame starting at a bit-count-0 boundary; s index = 2*line + slot.
    task automatic run_frame(input logic [3:0][23:0] s, input int drop_at, input int raise_at,
                             input int nbits, input bit chk_lat);
        logic          en0;
        logic [FW-1:0] exp;
        int            idx;
        int            slot;
        en0 = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            if (b == drop_at)  cap_en = 1'b0;
            if (b == raise_at) cap_en = 1'b1;
            if (b == 0)        en0 = cap_en;
            idx  = b % 32;
            slot = b / 32;
            for (int l = 0; l < NL; l++)
                mic_data[l] = (idx >= 1 && idx <= SW) ? s[l*2+slot][SW-idx] : 1'($urandom);
            if (b == 63 && en0 && cap_en) begin
                exp = '0;
                for (int k = 0; k < NCH; k++) begin
`ifdef MIC_CAP_STEREO_EN
                    exp[k*OW +: OW] = s[k][SW-1 -: OW];
`else
                    exp[k*OW +: OW] = s[2*k][SW-1 -: OW];
`endif
                end
                if (sb.size() < FD) sb.push_back(exp);
                else                exp_drop++;
            end
            if (b == 63 && chk_lat) begin
                repeat (3) @(negedge sys_clk);
                chk("valid_before_wrap", 64'(m_valid), 64'd0);
                @(negedge sys_clk);
            end else begin
                repeat (SD) @(negedge sys_clk);
            end
        end
    endtask

    task automatic measure();
        int   ws_lo = 0, ws_hi = 0, rises = 0, bad = 0, last = -1;
        logic prev = 1'b0;
        for (int j = 0; j < 256; j++) begin
            if (mic_ws) ws_hi++; else ws_lo++;
            if (mic_sck && !prev) begin
                if (last >= 0 && j - last != SD) bad++;
                last = j;
                rises++;
            end
            prev = mic_sck;
            @(negedge sys_clk);
        end
        chk("ws_low_cycles",  64'(ws_lo), 64'd128);
        chk("ws_high_cycles", 64'(ws_hi), 64'd128);
        chk("sck_rises",      64'(rises), 64'd64);
        chk("sck_period_bad", 64'(bad),   64'd0);
    endtask

    // Waits for the WS fall that marks bit count 0 so the next frame task is aligned.
    task automatic resync();
        logic prev;
        int   n = 0;
        prev = mic_ws;
        @(negedge sys_clk);
        while (!(prev && !mic_ws) && n < 600) begin
            prev = mic_ws;
            @(negedge sys_clk);
            n++;
        end
        chk("resync_in_time", 64'(n < 600), 64'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][23:0] p1;
        logic [3:0][23:0] r;
        p1 = {24'h800000, 24'h7FFFFF, 24'hABCDEF, 24'h123456};

        repeat (3) @(negedge sys_clk);
        chk_reset("por");

        m_ready = 1'b1;
        cap_en  = 1'b1;
        sys_rst = 1'b0;
        fork
            run_frame(p1, -1, -1, 64, 1'b1);
            measure();
        join
        chk("valid_after_wrap", 64'(m_valid), 64'd1);

        for (int i = 0; i < 2; i++) begin
            r = {$urandom, $urandom, $urandom};
            run_frame(r, -1, -1, 64, 1'b0);
        end

        // Capture-enable gating: dropped mid-frame, then low at frame start, then clean.
        r = {$urandom, $urandom, $urandom};
        run_frame(r, 40, -1, 64, 1'b0);
        r = {$urandom, $urandom, $urandom};
        run_frame(r, -1, 32, 64, 1'b0);
        r = {$urandom, $urandom, $urandom};
        run_frame(r, -1, -1, 64, 1'b0);
        cap_en = 1'b0;
        drain("drain_after_cap_en");

        m_ready = 1'b0;
        resync();
        for (int i = 0; i < 6; i++) begin
            r = {$urandom, $urandom, $urandom};
            run_frame(r, -1, (i == 0) ? 0 : -1, 64, 1'b0);
        end
        cap_en = 1'b0;
        chk("ovf_level", 64'(fifo_level), 64'(sb.size()));
        chk("ovf_flag",  64'(ovf),        64'd1);
        chk("ovf_count", 64'(ovf_cnt),    64'(exp_drop));
        ovf_clr = 1'b1;
        @(negedge sys_clk);
        ovf_clr  = 1'b0;
        exp_drop = 0;
        chk("ovf_clr_flag",  64'(ovf),     64'd0);
        chk("ovf_clr_count", 64'(ovf_cnt), 64'(exp_drop));
        m_ready = 1'b1;
        drain("drain_after_ovf");
        chk("level_after_drain", 64'(fifo_level), 64'd0);

        resync();
        m_ready = 1'b0;
        r = {$urandom, $urandom, $urandom};
        run_frame(r, -1, 0, 64, 1'b0);
        r = {$urandom, $urandom, $urandom};
        run_frame(r, -1, -1, 20, 1'b0);
        chk("level_before_rst", 64'(fifo_level), 64'(sb.size()));
        sys_rst = 1'b1;
        #1;
        chk_reset("mid_rst");
        sb.delete();
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        m_ready = 1'b1;
        r = {$urandom, $urandom, $urandom};
        run_frame(r, -1, -1, 64, 1'b1);
        chk("valid_after_rst_frame", 64'(m_valid), 64'd1);
        drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mic_array_capture.md
MIC_ARRAY_CAPTURE -- requirements
Module: mic_array_capture

Interface
REQ-001 SHALL have parameter NUM_LINES, default 2, meaning I2S data input lines (1..8).
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 24, meaning mic sample bits per slot (<=31).
REQ-003 SHALL have parameter OUT_WIDTH, default 16, meaning output bits per channel (<=SAMPLE_WIDTH).
REQ-004 SHALL have parameter SCK_DIV, default 20, meaning sys_clk cycles per SCK period (even, >=4).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning frame FIFO entries (power of 2, >=2).
REQ-006 SHALL have port sys_clk, input, 1, the single clock.
REQ-007 SHALL have port sys_rst, input, 1, reset: asynchronous, active-high.
REQ-008 SHALL have port cap_en, input, 1, capture enable.
REQ-009 SHALL have port mic_data, input, NUM_LINES, I2S serial data per line.
REQ-010 SHALL have port mic_sck, output, 1, mic bit clock.
REQ-011 SHALL have port mic_ws, output, 1, word select (0 = left slot).
REQ-012 SHALL have port m_data, output, NCH*OUT_WIDTH, one frame; channel 0 at LSBs.
REQ-013 SHALL have ports m_valid (output, 1) and m_ready (input, 1), the frame handshake.
REQ-014 SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1, stored frame count.
REQ-015 SHALL have ports ovf (output, 1, sticky overflow), ovf_cnt (output, 16, dropped frames) and ovf_clr (input, 1).

Function
REQ-016 SHALL free-run a divider 0..SCK_DIV-1; mic_sck rises when divider=SCK_DIV/2-1 and falls when divider=SCK_DIV-1, independent of cap_en.
REQ-017 SHALL keep bit counter 0..63, advanced on each SCK fall; mic_ws=0 for counts 0..31, 1 for 32..63.
REQ-018 SHALL sample mic_data on the sys_clk cycle of each SCK rise; slot bit indices 1..SAMPLE_WIDTH are data, MSB first; others ignored.
REQ-019 SHALL map channel k = 2*line + slot (L=0, R=1); NCH = 2*NUM_LINES.
REQ-020 SHALL output the top OUT_WIDTH bits of each sample (truncation, no rounding), two's complement preserved.
REQ-021 SHALL push the assembled frame on the sys_clk cycle the bit counter wraps 63->0, only if cap_en was high at count 0 and at the push; otherwise discard it.
REQ-022 SHALL make the FIFO first-word-fall-through: m_valid = not empty; pop when m_valid and m_ready.
REQ-023 SHALL drop a push when full with no pop in the same cycle, then set ovf and increment ovf_cnt (saturating at 0xFFFF).
REQ-024 SHALL accept a simultaneous push and pop when full, with no overflow.
REQ-025 SHALL give ovf_clr priority over a same-cycle overflow, clearing ovf and ovf_cnt to 0.

Reset
REQ-026 SHALL, under sys_rst, force mic_sck=0, mic_ws=0, divider=0, bit counter=0, FIFO empty, m_valid=0, m_data=0, fifo_level=0, ovf=0, ovf_cnt=0.
REQ-027 SHALL discard a partial frame when sys_rst is asserted mid-frame; the first frame pushed after release SHALL be the one starting at bit count 0.

Configuration
REQ-028 SHALL, with MIC_CAP_STEREO_EN defined, capture both slots (NCH = 2*NUM_LINES).
REQ-029 SHALL, with MIC_CAP_STEREO_EN undefined, capture left slots only (NCH = NUM_LINES, channel k = line k), leaving timing unchanged.

Structure
REQ-030 SHALL place constants FRAME_BITS=64 and SLOT_BITS=32, and the NCH derivation function, in shared package mic_cap_pkg.
REQ-031 SHALL implement the frame FIFO as sub-module mic_cap_fifo (synchronous, parametrised width/depth, level output).

Verification (SCK_DIV=4, NUM_LINES=2, SAMPLE_WIDTH=24, OUT_WIDTH=16)
REQ-032 SHALL check: reset release -> mic_sck period 4 cycles, mic_ws low 128 / high 128 cycles.
REQ-033 SHALL check: line0 L=0x123456, R=0xABCDEF; line1 L=0x7FFFFF, R=0x800000 -> channels 0..3 = 0x1234, 0xABCD, 0x7FFF, 0x8000, valid one cycle after wrap.
REQ-034 SHALL check: FIFO_DEPTH=4, m_ready=0, 6 frames -> fifo_level=4, ovf=1, ovf_cnt=2; then ovf_clr -> both 0.
REQ-035 SHALL check: cap_en dropped at bit count 40 -> that frame is not pushed, and the next full frame is pushed.
REQ-036 SHALL check: sys_rst pulsed at bit count 20 -> all REQ-026 values, and no partial frame output.
REQ-037 SHALL check: MIC_CAP_STEREO_EN undefined with the REQ-033 stimulus -> m_data = {0x7FFF, 0x1234}.
